rvcpu_run_ctrl: RTL and testbench

//  Synthesizable run controller for one or more rvcpu cores: sequences core reset, counts run cycles,

---
 rtl/rvcpu_pkg.sv | 13 +
 rtl/rvcpu_sat_counter.sv | 28 ++
 rtl/rvcpu_run_ctrl.sv | 108 ++++++++++
 tb/tb_rvcpu_run_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/rvcpu_pkg.sv
// Shared types for the rvcpu run controller: run-sequencer state encoding.
package rvcpu_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_RESET = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } run_state_t;

endpackage

// File: rtl/rvcpu_sat_counter.sv
// Clearable up-counter that sticks at all-ones; exposes its next value for same-cycle compares.
module rvcpu_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic [W-1:0] count_nxt
);

    always_comb begin
        count_nxt = count;
        if (clear)
            count_nxt = '0;
        else if (inc && (count != {W{1'b1}}))
            count_nxt = count + W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else
            count <= count_nxt;
    end

endmodule

// File: rtl/rvcpu_run_ctrl.sv
// Run controller for an array of rvcpu cores: reset sequencing, run-cycle count,
// halt collection with all/any completion, and a watchdog timeout.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | after reset; waiting for start with a nonzero enable mask
//   ST_RESET | all cores held in reset for RST_HOLD_CYCLES cycles
//   ST_RUN   | enabled cores released; counting cycles, collecting halts
//   ST_DONE  | run finished (halt or watchdog); results frozen
module rvcpu_run_ctrl
    import rvcpu_pkg::*;
#(
    parameter int NCORES          = 1,
    parameter int RST_HOLD_CYCLES = 2,
    parameter int CYC_W           = 32,
    parameter int HALT_ANY        = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [NCORES-1:0] core_enable,
    input  logic [CYC_W-1:0]  timeout_limit,
    input  logic [NCORES-1:0] core_halted,
    output logic [NCORES-1:0] core_rst_n,
    output logic              running,
    output logic              done,
    output logic              timed_out,
    output logic [NCORES-1:0] halted_mask,
    output logic [CYC_W-1:0]  cycle_count
);

    localparam int HOLD_W = (RST_HOLD_CYCLES > 1) ? $clog2(RST_HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(RST_HOLD_CYCLES - 1);

    run_state_t        state, state_nxt;
    logic [NCORES-1:0] en_q;
    logic [CYC_W-1:0]  limit_q;
    logic [HOLD_W-1:0] hold_q;
    logic [NCORES-1:0] mask_upd;
    logic [CYC_W-1:0]  count_nxt;
    logic              accept;
    logic              complete;
    logic              wdog_hit;

    rvcpu_sat_counter #(.W(CYC_W)) u_cycle_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (accept),
        .inc       (state == ST_RUN),
        .count     (cycle_count),
        .count_nxt (count_nxt)
    );

    // Completion is judged on the mask including this cycle's halts.
    always_comb begin
        accept    = start && (core_enable != '0) && ((state == ST_IDLE) || (state == ST_DONE));
        mask_upd  = halted_mask | (core_halted & en_q);
        complete  = (HALT_ANY != 0) ? (mask_upd != '0) : (mask_upd == en_q);
        wdog_hit  = (limit_q != '0) && (count_nxt == limit_q);
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: if (accept) state_nxt = ST_RESET;
            ST_RESET:         if (hold_q == '0) state_nxt = ST_RUN;
            ST_RUN:           if (complete || wdog_hit) state_nxt = ST_DONE;
            default:          state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q        <= '0;
            limit_q     <= '0;
            hold_q      <= '0;
            halted_mask <= '0;
            timed_out   <= 1'b0;
            running     <= 1'b0;
            done        <= 1'b0;
            core_rst_n  <= '0;
        end else begin
            if (accept) begin
                en_q        <= core_enable;
                limit_q     <= timeout_limit;
                hold_q      <= HOLD_LOAD;
                halted_mask <= '0;
                timed_out   <= 1'b0;
            end else if (state == ST_RESET) begin
                if (hold_q != '0)
                    hold_q <= hold_q - HOLD_W'(1);
            end else if (state == ST_RUN) begin
                halted_mask <= mask_upd;
                if (wdog_hit && !complete)
                    timed_out <= 1'b1;
            end
            running    <= (state_nxt == ST_RUN);
            done       <= (state_nxt == ST_DONE);
            // Cores stay released in DONE so their state can be inspected.
            core_rst_n <= ((state_nxt == ST_RUN) || (state_nxt == ST_DONE)) ? en_q : '0;
        end
    end

endmodule

// File: tb/tb_rvcpu_run_ctrl.sv
// Scoreboard bench: two controllers (all- and any-completion) driven by the same stimulus.
module tb_rvcpu_run_ctrl;

    localparam int NC    = 4;
    localparam int CW    = 8;
    localparam int HOLD  = 2;

    typedef int h_t [NC];
    typedef struct {
        logic [CW-1:0] cnt;
        logic [NC-1:0] mask;
        logic          to;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [NC-1:0] core_enable = '0;
    logic [CW-1:0] timeout_limit = '0;
    logic [NC-1:0] core_halted = '0;

    logic [NC-1:0] core_rst_n_a, core_rst_n_y, halted_mask_a, halted_mask_y;
    logic          running_a, running_y, done_a, done_y, timed_out_a, timed_out_y;
    logic [CW-1:0] cycle_count_a, cycle_count_y;

    int   tests = 0;
    int   fails = 0;
    exp_t q_all[$];
    exp_t q_any[$];
    logic done_a_d = 1'b0;
    logic done_y_d = 1'b0;

    always #5 clk = ~clk;

    rvcpu_run_ctrl #(.NCORES(NC), .RST_HOLD_CYCLES(HOLD), .CYC_W(CW), .HALT_ANY(0)) dut_all (
        .clk(clk), .rst_n(rst_n), .start(start), .core_enable(core_enable),
        .timeout_limit(timeout_limit), .core_halted(core_halted), .core_rst_n(core_rst_n_a),
        .running(running_a), .done(done_a), .timed_out(timed_out_a),
        .halted_mask(halted_mask_a), .cycle_count(cycle_count_a)
    );

    rvcpu_run_ctrl #(.NCORES(NC), .RST_HOLD_CYCLES(HOLD), .CYC_W(CW), .HALT_ANY(1)) dut_any (
        .clk(clk), .rst_n(rst_n), .start(start), .core_enable(core_enable),
        .timeout_limit(timeout_limit), .core_halted(core_halted), .core_rst_n(core_rst_n_y),
        .running(running_y), .done(done_y), .timed_out(timed_out_y),
        .halted_mask(halted_mask_y), .cycle_count(cycle_count_y)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: walk RUN cycles; core i is seen halted from RUN cycle h[i] onward (0 = never).
    function automatic exp_t model(input logic [NC-1:0] en, input logic [CW-1:0] lim,
                                   input h_t h, input bit any);
        exp_t          r;
        int            c;
        logic [NC-1:0] m;
        r.cnt = '0; r.mask = '0; r.to = 1'b0;
        for (int t = 1; t <= 2000; t++) begin
            c = (t > 255) ? 255 : t;
            m = '0;
            for (int i = 0; i < NC; i++)
                if (en[i] && h[i] != 0 && h[i] <= t) m[i] = 1'b1;
            r.cnt  = CW'(c);
            r.mask = m;
            if (any ? (m != '0) : (m == en)) return r;
            if (lim != '0 && CW'(c) == lim) begin
                r.to = 1'b1;
                return r;
            end
        end
        return r;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (done_a && !done_a_d) begin
            if (q_all.size() == 0) chk("all_unexpected_done", 1, 0);
            else begin
                e = q_all.pop_front();
                chk("all_cycle_count", cycle_count_a, e.cnt);
                chk("all_halted_mask", halted_mask_a, e.mask);
                chk("all_timed_out", timed_out_a, e.to);
            end
        end
        if (done_y && !done_y_d) begin
            if (q_any.size() == 0) chk("any_unexpected_done", 1, 0);
            else begin
                e = q_any.pop_front();
                chk("any_cycle_count", cycle_count_y, e.cnt);
                chk("any_halted_mask", halted_mask_y, e.mask);
                chk("any_timed_out", timed_out_y, e.to);
            end
        end
        done_a_d = done_a;
        done_y_d = done_y;
    end

    task automatic run(input logic [NC-1:0] en, input logic [CW-1:0] lim, input h_t h, input bit hold);
        exp_t          ea, ey;
        logic [NC-1:0] hv;
        int            t;
        bit            finished;
        ea = model(en, lim, h, 1'b0);
        ey = model(en, lim, h, 1'b1);
        q_all.push_back(ea);
        q_any.push_back(ey);
        @(negedge clk);
        core_halted = '0; core_enable = en; timeout_limit = lim; start = 1'b1;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        core_enable   = NC'($urandom);
        timeout_limit = CW'($urandom);
        chk("restart_count_clear", {cycle_count_a, cycle_count_y}, 0);
        chk("restart_mask_clear", {halted_mask_a, halted_mask_y}, 0);
        chk("restart_timeout_clear", {timed_out_a, timed_out_y}, 0);
        for (int k = 0; k < HOLD; k++) begin
            chk("reset_hold_core_rst", {core_rst_n_a, core_rst_n_y}, 0);
            chk("reset_hold_running", {running_a, running_y, done_a, done_y}, 0);
            @(posedge clk); #1;
        end
        chk("run_entry_running", {running_a, running_y}, 2'b11);
        t = 1;
        finished = 1'b0;
        while (!finished) begin
            chk("run_core_rst_all", core_rst_n_a, en);
            chk("run_core_rst_any", core_rst_n_y, en);
            for (int i = 0; i < NC; i++) hv[i] = (h[i] != 0 && h[i] <= t);
            core_halted = hv;
            @(posedge clk); #1;
            if (done_a && done_y) begin
                finished = 1'b1;
                start = 1'b0;
            end
            t++;
            if (t > 400) begin
                chk("run_cycle_budget", 0, 1);
                finished = 1'b1;
                start = 1'b0;
            end
        end
        core_halted = '0;
        @(posedge clk); #1;
        chk("done_mask_sticky_all", halted_mask_a, ea.mask);
        chk("done_mask_sticky_any", halted_mask_y, ey.mask);
        chk("done_count_frozen_all", cycle_count_a, ea.cnt);
        chk("done_hold", {done_a, done_y, running_a, running_y}, 4'b1100);
    endtask

    task automatic check_reset_values(input string nm);
        chk({nm, "_all"}, {core_rst_n_a, running_a, done_a, timed_out_a, halted_mask_a, cycle_count_a}, 0);
        chk({nm, "_any"}, {core_rst_n_y, running_y, done_y, timed_out_y, halted_mask_y, cycle_count_y}, 0);
    endtask

    initial begin
        h_t            h;
        logic [NC-1:0] en;
        logic [CW-1:0] lim;

        #23;
        check_reset_values("reset_state");
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check_reset_values("idle_after_release");

        run(4'b0001, 8'd0, '{10, 0, 0, 0}, 1'b0);
        run(4'b1011, 8'd0, '{5, 9, 3, 20}, 1'b0);
        run(4'b1011, 8'd40, '{0, 0, 0, 7}, 1'b0);
        run(4'b0001, 8'd50, '{0, 0, 0, 0}, 1'b0);
        run(4'b0001, 8'd50, '{50, 0, 0, 0}, 1'b0);
        run(4'b0001, 8'd0, '{300, 0, 0, 0}, 1'b0);
        run(4'b0001, 8'd0, '{12, 0, 0, 0}, 1'b1);

        for (int n = 0; n < 20; n++) begin
            en  = NC'($urandom_range(1, 15));
            lim = ($urandom_range(0, 1) == 1) ? CW'($urandom_range(1, 60)) : '0;
            for (int i = 0; i < NC; i++)
                h[i] = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 60);
            if (lim == '0)
                for (int i = 0; i < NC; i++)
                    if (en[i] && h[i] == 0) h[i] = $urandom_range(1, 60);
            run(en, lim, h, 1'b0);
        end

        // Asynchronous reset in the middle of a run, at RUN cycle 30.
        @(negedge clk);
        core_halted = '0; core_enable = 4'b0111; timeout_limit = '0; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (HOLD + 29) @(posedge clk);
        #2;
        chk("midrun_count", cycle_count_a, 29);
        chk("midrun_running", running_a, 1);
        rst_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        @(negedge clk); rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check_reset_values("no_resume");

        // start with an empty enable mask is ignored.
        @(negedge clk); start = 1'b1; core_enable = '0; timeout_limit = 8'd9;
        repeat (5) @(posedge clk);
        #1;
        check_reset_values("start_empty_enable");
        start = 1'b0;

        run(4'b0110, 8'd0, '{0, 4, 8, 0}, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", q_all.size() + q_any.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
